// File: rtl/avalon_mem_slave.sv
// Avalon-MM memory slave: word storage behind a pipelined read path
// and a write path with a configurable number of waitrequest stalls.
module avalon_mem_slave #(
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LATENCY = 2,
    parameter int WR_WAIT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] avs_s0_address,
    input  logic [31:0] avs_s0_writedata,
    input  logic [3:0]  avs_s0_byteenable,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic        avs_s0_chipselect,
    output logic [31:0] avs_s0_readdata,
    output logic        avs_s0_readdatavalid,
    output logic        avs_s0_waitrequest
);

    localparam int         WORDS = 2 ** DEPTH_LOG2;
    localparam logic [2:0] WW    = 3'(WR_WAIT);

    typedef enum logic {
        W_IDLE,
        W_STALL
    } wstate_t;

    logic [31:0]           mem [WORDS];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  wr_req;
    logic                  rd_req;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [2:0]            wcnt;
    wstate_t               wstate;

    logic [RD_LATENCY-1:0] vld;
    logic [31:0]           dat [RD_LATENCY];

    // Byte-lane and high address bits are don't-care: upper addresses alias.
    logic unused_addr;
    assign unused_addr = ^{avs_s0_address[31:DEPTH_LOG2+2],
                           avs_s0_address[1:0]};

    assign idx    = avs_s0_address[DEPTH_LOG2+1:2];
    assign wr_req = avs_s0_chipselect & avs_s0_write;
    assign rd_req = avs_s0_chipselect & avs_s0_read & ~avs_s0_write;

    // Stall follows the counter even while reset is high.
    assign avs_s0_waitrequest = wr_req & (wcnt != WW);

    assign wr_acc = wr_req & ~avs_s0_waitrequest & ~reset;
    assign rd_acc = rd_req & ~reset;

    // Write stall FSM: count stalled cycles until WR_WAIT is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            wstate <= W_IDLE;
            wcnt   <= 3'd0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (wr_req && avs_s0_waitrequest) begin
                        wstate <= W_STALL;
                        wcnt   <= wcnt + 3'd1;
                    end
                end
                W_STALL: begin
                    if (!wr_req || !avs_s0_waitrequest) begin
                        wstate <= W_IDLE;
                        wcnt   <= 3'd0;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                default: begin
                    wstate <= W_IDLE;
                    wcnt   <= 3'd0;
                end
            endcase
        end
    end

    // Storage update with per-byte enables; not touched by reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_s0_byteenable[b]) begin
                    mem[idx][8*b +: 8] <= avs_s0_writedata[8*b +: 8];
                end
            end
        end
    end

    // Read latency pipe: data stages only load behind a valid, so the
    // last stage holds the most recently returned word between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat[i] <= 32'h0;
            end
        end else begin
            vld[0] <= rd_acc;
            if (rd_acc) begin
                dat[0] <= mem[idx];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign avs_s0_readdatavalid = vld[RD_LATENCY-1];
    assign avs_s0_readdata      = dat[RD_LATENCY-1];

endmodule

// File: doc/avalon_mem_slave.md
AVALON_MEM_SLAVE -- requirements
Module: avalon_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of word count of internal storage.
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning cycles from read acceptance to readdatavalid (legal 1..4).
REQ-003 SHALL have parameter WR_WAIT, default 1, meaning waitrequest cycles inserted per write (legal 0..7).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port avs_s0_address  input  32  byte address; word index = address[DEPTH_LOG2+1:2].
REQ-007 SHALL have port avs_s0_writedata  input  32  write data.
REQ-008 SHALL have port avs_s0_byteenable  input  4  per-byte write enable; bit i covers bits 8i+7:8i.
REQ-009 SHALL have port avs_s0_read  input  1  read request.
REQ-010 SHALL have port avs_s0_write  input  1  write request.
REQ-011 SHALL have port avs_s0_chipselect  input  1  request qualifier; read/write ignored when low.
REQ-012 SHALL have port avs_s0_readdata  output  32  read data, valid when readdatavalid high.
REQ-013 SHALL have port avs_s0_readdatavalid  output  1  one-cycle strobe per returned read.
REQ-014 SHALL have port avs_s0_waitrequest  output  1  stall; request held by master while high.

Function
REQ-015 SHALL act as the downstream target of the write buffer master port: Avalon-MM slave backed by 2^DEPTH_LOG2 x 32 storage.
REQ-016 SHALL ignore address bits [1:0] and bits above DEPTH_LOG2+1 (upper addresses alias).
REQ-017 SHALL treat cs&write as a write request and cs&read&!write as a read request; cs&read&write SHALL be handled as write only, read dropped.
REQ-018 SHALL drive waitrequest combinationally = cs & write & (wcnt != WR_WAIT); 0 in all other cases, including idle.
REQ-019 SHALL keep 3-bit wcnt: increments each cycle a write request is stalled; clears on write acceptance or when request drops.
REQ-020 SHALL accept a write on the edge where write request is present and waitrequest low; only bytes with byteenable=1 updated; byteenable 0000 SHALL be accepted with no storage change.
REQ-021 SHALL with WR_WAIT=0 accept writes in the request cycle (zero stall).
REQ-022 SHALL accept a read in every cycle it is requested (never stall reads); pipeline fully, one read per cycle sustained.
REQ-023 SHALL assert readdatavalid exactly RD_LATENCY cycles after the acceptance edge, in acceptance order, one strobe per read.
REQ-024 SHALL sample storage for a read at acceptance; a write accepted on the same edge to the same word is not visible; a read accepted on a later edge sees it.
REQ-025 SHALL hold readdata at last returned value between strobes.
REQ-026 SHALL implement the latency pipe as RD_LATENCY-stage valid/data shift register; no FSM for reads.
REQ-027 SHALL implement write stall as two-state FSM: W_IDLE (wcnt=0, no stalled write) and W_STALL (write held, wcnt<WR_WAIT); W_IDLE->W_STALL on write request when WR_WAIT>0; W_STALL->W_IDLE on acceptance or request drop.
REQ-028 SHALL allow a read request while reads are pending in the pipe and while a write was accepted the previous cycle.

Reset
REQ-029 SHALL on reset: readdatavalid=0, readdata=32'h0, all pipe valid bits cleared, wcnt=0, FSM=W_IDLE.
REQ-030 SHALL drop reads in flight when reset asserts mid-pipe (no later strobe).
REQ-031 SHALL leave storage contents unchanged by reset (undefined after power-up).
REQ-032 SHALL ignore all requests in cycles where reset is high; waitrequest SHALL still follow REQ-018.

Verification
REQ-033 SHALL pass: write 32'hA0A0A0A0 to 32'h00002000, be=1111, WR_WAIT=1 -> waitrequest high 1 cycle then low; read 32'h00002000 -> readdatavalid 2 cycles after acceptance, readdata 32'hA0A0A0A0.
REQ-034 SHALL pass: then write 32'h21212121 to 32'h00002000, be=0011 -> subsequent read returns 32'hA0A02121.
REQ-035 SHALL pass: reads to 32'h10001000, 32'h10001004, 32'h10001008 on 3 consecutive cycles (preloaded 1,2,3) -> waitrequest stays 0; readdatavalid high 3 consecutive cycles, data 1,2,3 in order.
REQ-036 SHALL pass: read issued, reset asserted 1 cycle later for 1 cycle -> no readdatavalid strobe; readdata 32'h0.
REQ-037 SHALL pass: cs=1, read=1, write=1, address 32'h00003000, data 32'h55AA55AA -> write performed, no readdatavalid; later read of 32'h00103000 (alias, DEPTH_LOG2=8) returns 32'h55AA55AA.
REQ-038 SHALL pass: write with cs=0 -> waitrequest 0, storage unchanged.
